// File: rtl/frame_sequencer.sv
// Frame-ID sequencer: steps the SDRAM-to-VGA reader through a run of stored images,
// changing the displayed ID only on VGA frame boundaries.
module frame_sequencer #(
  parameter int unsigned ID_W  = 6,
  parameter int unsigned NUM_W = 7,
  parameter int unsigned CNT_W = 16
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iENABLE,
  input  logic             iTRIGGER,
  input  logic             iFRAME_START,
  input  logic [ID_W-1:0]  iMANUAL_ID,
  input  logic [ID_W-1:0]  iSTART_ID,
  input  logic [NUM_W-1:0] iNUM_IMAGES,
  input  logic [CNT_W-1:0] iCYCLES,
  input  logic             iLOOP,
  output logic [ID_W-1:0]  oFRAME_ID,
  output logic             oBUSY,
  output logic [NUM_W-1:0] oIMAGE_INDEX,
  output logic             oDONE,
  output logic             oERROR
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StShow  = 2'd2
  } state_e;

  state_e           r_state, w_state_d;
  logic             r_trig_q;
  logic [ID_W-1:0]  r_frame_id, w_frame_id_d;
  logic [NUM_W-1:0] r_index, w_index_d;
  logic [CNT_W-1:0] r_cyc_cnt, w_cyc_cnt_d;
  logic             r_done, w_done_d;
  logic             r_error, w_error_d;
  logic [ID_W-1:0]  r_start, w_start_d;
  logic [NUM_W-1:0] r_num, w_num_d;
  logic [CNT_W-1:0] r_cycles, w_cycles_d;
  logic             r_loop, w_loop_d;

  logic w_edge;
  logic w_params_ok;
  logic w_accept;
  logic w_reject;
  logic w_last_cycle;
  logic w_last_image;

  assign w_edge       = iTRIGGER & ~r_trig_q;
  assign w_params_ok  = (iNUM_IMAGES != '0) && (iCYCLES != '0);
  assign w_accept     = w_edge & iENABLE & w_params_ok;
  assign w_reject     = w_edge & iENABLE & ~w_params_ok;
  assign w_last_cycle = (r_cyc_cnt == r_cycles - CNT_W'(1));
  assign w_last_image = (r_index == r_num - NUM_W'(1));

  always_comb begin
    w_state_d    = r_state;
    w_frame_id_d = r_frame_id;
    w_index_d    = r_index;
    w_cyc_cnt_d  = r_cyc_cnt;
    w_done_d     = 1'b0;
    w_error_d    = r_error;
    w_start_d    = r_start;
    w_num_d      = r_num;
    w_cycles_d   = r_cycles;
    w_loop_d     = r_loop;

    if (!iENABLE) begin
      // Disabled: abandon any sequence, keep tracking the switches at boundaries.
      w_state_d   = StIdle;
      w_cyc_cnt_d = '0;
      w_index_d   = '0;
      if (iFRAME_START) begin
        w_frame_id_d = iMANUAL_ID;
      end
    end else if (w_accept) begin
      w_start_d  = iSTART_ID;
      w_num_d    = iNUM_IMAGES;
      w_cycles_d = iCYCLES;
      w_loop_d   = iLOOP;
      w_error_d  = 1'b0;
      w_state_d  = StArmed;
      // A coincident boundary is honoured in IDLE but dropped by a retrigger.
      if ((r_state == StIdle) && iFRAME_START) begin
        w_frame_id_d = iMANUAL_ID;
      end
    end else begin
      if (w_reject) begin
        w_error_d = 1'b1;
      end
      if (iFRAME_START) begin
        unique case (r_state)
          StIdle: begin
            w_frame_id_d = iMANUAL_ID;
          end
          StArmed: begin
            w_frame_id_d = r_start;
            w_index_d    = '0;
            w_cyc_cnt_d  = '0;
            w_state_d    = StShow;
          end
          StShow: begin
            if (!w_last_cycle) begin
              w_cyc_cnt_d = r_cyc_cnt + CNT_W'(1);
            end else begin
              w_cyc_cnt_d = '0;
              if (!w_last_image) begin
                w_index_d    = r_index + NUM_W'(1);
                w_frame_id_d = r_frame_id + ID_W'(1);
              end else if (r_loop) begin
                w_index_d    = '0;
                w_frame_id_d = r_start;
              end else begin
                w_state_d    = StIdle;
                w_frame_id_d = iMANUAL_ID;
                w_done_d     = 1'b1;
              end
            end
          end
          default: begin
            w_state_d = StIdle;
          end
        endcase
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state    <= StIdle;
      r_trig_q   <= 1'b0;
      r_frame_id <= '0;
      r_index    <= '0;
      r_cyc_cnt  <= '0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_start    <= '0;
      r_num      <= '0;
      r_cycles   <= '0;
      r_loop     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_trig_q   <= iTRIGGER;
      r_frame_id <= w_frame_id_d;
      r_index    <= w_index_d;
      r_cyc_cnt  <= w_cyc_cnt_d;
      r_done     <= w_done_d;
      r_error    <= w_error_d;
      r_start    <= w_start_d;
      r_num      <= w_num_d;
      r_cycles   <= w_cycles_d;
      r_loop     <= w_loop_d;
    end
  end

  assign oFRAME_ID    = r_frame_id;
  assign oBUSY        = (r_state == StArmed) || (r_state == StShow);
  assign oIMAGE_INDEX = r_index;
  assign oDONE        = r_done;
  assign oERROR       = r_error;

endmodule

// File: tb/tb_frame_sequencer.sv
// Scoreboard bench for frame_sequencer: stimulus queues expected outputs, a monitor
// compares them after every frame pulse or probe cycle.
module tb_frame_sequencer;

  typedef struct packed {
    logic [5:0] id;
    logic [6:0] idx;
    logic       busy;
    logic       done;
    logic       err;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        trigger;
  logic        fs;
  logic        probe;
  logic [5:0]  manual_id;
  logic [5:0]  start_id;
  logic [6:0]  num_images;
  logic [15:0] cycles;
  logic        loop_en;
  logic [5:0]  frame_id;
  logic        busy;
  logic [6:0]  image_index;
  logic        done;
  logic        error;

  exp_t q_exp[$];
  int   n_vec;
  int   n_bad;

  frame_sequencer #(
    .ID_W (6),
    .NUM_W(7),
    .CNT_W(16)
  ) dut (
    .iCLK        (clk),
    .iRST        (rst),
    .iENABLE     (enable),
    .iTRIGGER    (trigger),
    .iFRAME_START(fs),
    .iMANUAL_ID  (manual_id),
    .iSTART_ID   (start_id),
    .iNUM_IMAGES (num_images),
    .iCYCLES     (cycles),
    .iLOOP       (loop_en),
    .oFRAME_ID   (frame_id),
    .oBUSY       (busy),
    .oIMAGE_INDEX(image_index),
    .oDONE       (done),
    .oERROR      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [5:0] id, input logic [6:0] idx, input logic b,
                              input logic d, input logic e);
    exp_t x;
    x.id = id; x.idx = idx; x.busy = b; x.done = d; x.err = e;
    return x;
  endfunction

  // Monitor: one expected entry per frame pulse or probe cycle.
  initial begin
    forever begin
      @(posedge clk);
      if (fs || probe) begin
        #1;
        if (q_exp.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_output: scoreboard empty at t=%0t", $time);
        end else begin
          exp_t e;
          e = q_exp.pop_front();
          n_vec++;
          if (frame_id !== e.id || busy !== e.busy || done !== e.done || error !== e.err ||
              (e.busy && image_index !== e.idx)) begin
            n_bad++;
            $display("FAIL vec%0d: got id=%0d idx=%0d busy=%b done=%b err=%b, want id=%0d idx=%0d busy=%b done=%b err=%b",
                     n_vec, frame_id, image_index, busy, done, error,
                     e.id, e.idx, e.busy, e.done, e.err);
          end
        end
      end
    end
  end

  task automatic pulse(input exp_t e);
    @(negedge clk);
    q_exp.push_back(e);
    fs = 1'b1;
    @(negedge clk);
    fs = 1'b0;
  endtask

  task automatic probe_chk(input exp_t e);
    @(negedge clk);
    q_exp.push_back(e);
    probe = 1'b1;
    @(negedge clk);
    probe = 1'b0;
  endtask

  task automatic trig();
    @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ids2[8];
    logic [6:0] idx2[8];
    logic [5:0] ids3[10];
    n_vec = 0; n_bad = 0;
    rst = 1'b1; enable = 1'b1; trigger = 1'b0; fs = 1'b0; probe = 1'b0;
    manual_id = 6'd5; start_id = '0; num_images = '0; cycles = '0; loop_en = 1'b0;

    // Reset state, then manual ID picked up at a boundary
    probe_chk(mk(6'd0, 7'd0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    rst = 1'b0;
    probe_chk(mk(6'd0, 7'd0, 1'b0, 1'b0, 1'b0));
    pulse(mk(6'd5, 7'd0, 1'b0, 1'b0, 1'b0));

    // Run-once sequence: 10,10,11,11,12,12 then manual, done at 7th pulse
    start_id = 6'd10; num_images = 7'd3; cycles = 16'd2; loop_en = 1'b0;
    trig();
    start_id = 6'd40; num_images = 7'd9; cycles = 16'd7; loop_en = 1'b1;
    probe_chk(mk(6'd5, 7'd0, 1'b1, 1'b0, 1'b0));
    ids2 = '{6'd10, 6'd10, 6'd11, 6'd11, 6'd12, 6'd12, 6'd5, 6'd5};
    idx2 = '{7'd0, 7'd0, 7'd1, 7'd1, 7'd2, 7'd2, 7'd0, 7'd0};
    for (int i = 0; i < 8; i++) begin
      pulse(mk(ids2[i], idx2[i], (i < 6), (i == 6), 1'b0));
    end

    // Looping sequence with frame-ID wrap 63 -> 0
    start_id = 6'd62; num_images = 7'd4; cycles = 16'd1; loop_en = 1'b1;
    trig();
    ids3 = '{6'd62, 6'd63, 6'd0, 6'd1, 6'd62, 6'd63, 6'd0, 6'd1, 6'd62, 6'd63};
    for (int i = 0; i < 10; i++) begin
      pulse(mk(ids3[i], 7'(i % 4), 1'b1, 1'b0, 1'b0));
    end
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    probe_chk(mk(6'd63, 7'd0, 1'b0, 1'b0, 1'b0));

    // Rejected trigger sets sticky error, valid trigger clears it
    num_images = 7'd0;
    trig();
    probe_chk(mk(6'd63, 7'd0, 1'b0, 1'b0, 1'b1));
    start_id = 6'd10; num_images = 7'd3; cycles = 16'd2; loop_en = 1'b0;
    trig();
    probe_chk(mk(6'd63, 7'd0, 1'b1, 1'b0, 1'b0));

    // Abort at image index 1 by dropping enable, trigger held high
    pulse(mk(6'd10, 7'd0, 1'b1, 1'b0, 1'b0));
    pulse(mk(6'd10, 7'd0, 1'b1, 1'b0, 1'b0));
    pulse(mk(6'd11, 7'd1, 1'b1, 1'b0, 1'b0));
    @(negedge clk);
    enable = 1'b0;
    trigger = 1'b1;
    q_exp.push_back(mk(6'd11, 7'd0, 1'b0, 1'b0, 1'b0));
    probe = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    probe = 1'b0;
    probe_chk(mk(6'd11, 7'd0, 1'b0, 1'b0, 1'b0));
    pulse(mk(6'd5, 7'd0, 1'b0, 1'b0, 1'b0));
    probe_chk(mk(6'd5, 7'd0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    trigger = 1'b0;

    // Edge coincident with a boundary in IDLE
    manual_id = 6'd3; start_id = 6'd20; num_images = 7'd2; cycles = 16'd1; loop_en = 1'b0;
    @(negedge clk);
    q_exp.push_back(mk(6'd3, 7'd0, 1'b1, 1'b0, 1'b0));
    trigger = 1'b1;
    fs = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    fs = 1'b0;
    pulse(mk(6'd20, 7'd0, 1'b1, 1'b0, 1'b0));
    pulse(mk(6'd21, 7'd1, 1'b1, 1'b0, 1'b0));
    pulse(mk(6'd3, 7'd0, 1'b0, 1'b1, 1'b0));
    probe_chk(mk(6'd3, 7'd0, 1'b0, 1'b0, 1'b0));

    repeat (3) @(negedge clk);
    if (q_exp.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", q_exp.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
